// File: rtl/ls_unit_pkg.sv
// Shared LSU types: opcode encoding, ROB tag, memory-controller sizes, FSM states.
package ls_unit_pkg;

    localparam int unsigned OPENUM_W = 3;
    localparam int unsigned ROB_ID_W = 4;

    // Loads occupy the low codes, stores the high ones: op >= OPENUM_SB means store.
    typedef enum logic [OPENUM_W-1:0] {
        OPENUM_LB  = 3'd0,
        OPENUM_LH  = 3'd1,
        OPENUM_LW  = 3'd2,
        OPENUM_LBU = 3'd3,
        OPENUM_LHU = 3'd4,
        OPENUM_SB  = 3'd5,
        OPENUM_SH  = 3'd6,
        OPENUM_SW  = 3'd7
    } openum_e;

    typedef logic [ROB_ID_W-1:0] rob_id_t;
    localparam rob_id_t ZERO_ROB = '0;

    localparam logic [1:0] MC_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MC_SIZE_HALF = 2'd1;
    localparam logic [1:0] MC_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_DRAIN = 2'd2
    } ls_state_e;

    function automatic logic op_is_store(openum_e op);
        return op >= OPENUM_SB;
    endfunction

    function automatic logic [1:0] op_mc_size(openum_e op);
        case (op)
            OPENUM_LB, OPENUM_LBU, OPENUM_SB: return MC_SIZE_BYTE;
            OPENUM_LH, OPENUM_LHU, OPENUM_SH: return MC_SIZE_HALF;
            default:                          return MC_SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/ls_unit_if.sv
// LSU bus bundle: LS-buffer request/busy, memory-controller request/response, CDB broadcast.
interface ls_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic                    enable_signal_from_lsb;
    ls_unit_pkg::openum_e    openum_from_lsb;
    logic [ADDR_W-1:0]       mem_address_from_lsb;
    logic [DATA_W-1:0]       stored_data_from_lsb;
    ls_unit_pkg::rob_id_t    rob_id_from_lsb;
    logic                    busy_signal_to_lsb;

    logic                    mc_req_valid;
    logic                    mc_we;
    logic [ADDR_W-1:0]       mc_addr;
    logic [1:0]              mc_size;
    logic [DATA_W-1:0]       mc_wdata;
    logic                    mc_done;
    logic [DATA_W-1:0]       mc_rdata;

    logic                    valid_signal_to_cdb;
    ls_unit_pkg::rob_id_t    rob_id_to_cdb;
    logic [DATA_W-1:0]       result_to_cdb;

    // LSU side
    modport slave (
        input  enable_signal_from_lsb, openum_from_lsb, mem_address_from_lsb,
               stored_data_from_lsb, rob_id_from_lsb, mc_done, mc_rdata,
        output busy_signal_to_lsb, mc_req_valid, mc_we, mc_addr, mc_size, mc_wdata,
               valid_signal_to_cdb, rob_id_to_cdb, result_to_cdb
    );

    // Environment side: LS buffer, memory controller and CDB listeners
    modport master (
        output enable_signal_from_lsb, openum_from_lsb, mem_address_from_lsb,
               stored_data_from_lsb, rob_id_from_lsb, mc_done, mc_rdata,
        input  busy_signal_to_lsb, mc_req_valid, mc_we, mc_addr, mc_size, mc_wdata,
               valid_signal_to_cdb, rob_id_to_cdb, result_to_cdb
    );

endinterface

// File: rtl/ls_unit_load_extender.sv
// Combinational load-result extension from opcode and zero-padded raw memory data.
module load_extender
    import ls_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  openum_e           op_i,
    input  logic [DATA_W-1:0] raw_i,
    output logic [DATA_W-1:0] result_o
);

    // Select sign/zero extension by load width
    always_comb begin
        result_o = raw_i;
        case (op_i)
            OPENUM_LB:  result_o = {{(DATA_W-8){raw_i[7]}}, raw_i[7:0]};
            OPENUM_LH:  result_o = {{(DATA_W-16){raw_i[15]}}, raw_i[15:0]};
            OPENUM_LBU: result_o = {{(DATA_W-8){1'b0}}, raw_i[7:0]};
            OPENUM_LHU: result_o = {{(DATA_W-16){1'b0}}, raw_i[15:0]};
            default:    result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/ls_unit.sv
// Load/store unit: one request at a time from the LS buffer, executed on the memory
// controller; load results are extended and broadcast on the CDB for one cycle.
module ls_unit
    import ls_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       misbranch_flag,
    ls_unit_if.slave   bus
);

    ls_state_e         state_q;
    openum_e           op_q;
    rob_id_t           rob_q;
    logic              mc_req_valid_q;
    logic              mc_we_q;
    logic [ADDR_W-1:0] mc_addr_q;
    logic [1:0]        mc_size_q;
    logic [DATA_W-1:0] mc_wdata_q;
    logic              cdb_valid_q;
    rob_id_t           cdb_rob_q;
    logic [DATA_W-1:0] cdb_result_q;
    logic [DATA_W-1:0] ext_result;

    load_extender #(.DATA_W(DATA_W)) u_ext (
        .op_i     (op_q),
        .raw_i    (bus.mc_rdata),
        .result_o (ext_result)
    );

    // Combinational so the acceptance cycle already reports busy
    assign bus.busy_signal_to_lsb = (state_q != ST_IDLE) || bus.enable_signal_from_lsb;

    assign bus.mc_req_valid        = mc_req_valid_q;
    assign bus.mc_we               = mc_we_q;
    assign bus.mc_addr             = mc_addr_q;
    assign bus.mc_size             = mc_size_q;
    assign bus.mc_wdata            = mc_wdata_q;
    assign bus.valid_signal_to_cdb = cdb_valid_q;
    assign bus.rob_id_to_cdb       = cdb_rob_q;
    assign bus.result_to_cdb       = cdb_result_q;

    // Request FSM with registered memory and CDB outputs; DRAIN marks a squashed load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OPENUM_LB;
            rob_q          <= ZERO_ROB;
            mc_req_valid_q <= 1'b0;
            mc_we_q        <= 1'b0;
            mc_addr_q      <= '0;
            mc_size_q      <= MC_SIZE_BYTE;
            mc_wdata_q     <= '0;
            cdb_valid_q    <= 1'b0;
            cdb_rob_q      <= ZERO_ROB;
            cdb_result_q   <= '0;
        end else if (rdy) begin
            cdb_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable_signal_from_lsb && !misbranch_flag) begin
                        op_q           <= bus.openum_from_lsb;
                        rob_q          <= bus.rob_id_from_lsb;
                        mc_req_valid_q <= 1'b1;
                        mc_we_q        <= op_is_store(bus.openum_from_lsb);
                        mc_addr_q      <= bus.mem_address_from_lsb;
                        mc_size_q      <= op_mc_size(bus.openum_from_lsb);
                        mc_wdata_q     <= bus.stored_data_from_lsb;
                        state_q        <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (bus.mc_done) begin
                        mc_req_valid_q <= 1'b0;
                        state_q        <= ST_IDLE;
                        if (!op_is_store(op_q) && !misbranch_flag) begin
                            cdb_valid_q  <= 1'b1;
                            cdb_rob_q    <= rob_q;
                            cdb_result_q <= ext_result;
                        end
                    end else if (misbranch_flag && !op_is_store(op_q)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.mc_done) begin
                        mc_req_valid_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
